// File: rtl/song_sequencer.sv
// Note-highway game controller: song FSM, beat-timer control, pattern ROM streaming
// into the note track, and key judging against the hit row with score/combo/misses.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEAD_IN | countdown of LEAD_IN beat ticks, keys ignored
// PLAY    | track scrolls one row per tick, keys judged on row 0
// PAUSE   | ticks and keys ignored, everything frozen
// DONE    | last note has left the hit row
module song_sequencer #(
  parameter int NUM_LANES   = 3,
  parameter int TRACK_DEPTH = 8,
  parameter int SONG_LEN    = 64,
  parameter int ADDR_W      = 6,
  parameter int LEAD_IN     = 4,
  parameter int SCORE_W     = 16
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             start_btn,
  input  logic                             pause_btn,
  input  logic                             shift,
  input  logic [NUM_LANES-1:0]             keys,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [NUM_LANES-1:0]             rom_data,
  output logic                             timer_start,
  output logic                             timer_stop,
  output logic [NUM_LANES*TRACK_DEPTH-1:0] track,
  output logic [SCORE_W-1:0]               score,
  output logic [7:0]                       combo,
  output logic [7:0]                       misses,
  output logic [2:0]                       state,
  output logic                             song_done
);

  localparam int ROW_W = $clog2(SONG_LEN + TRACK_DEPTH + 1);
  localparam int TRK_W = NUM_LANES * TRACK_DEPTH;
  localparam int SW1   = SCORE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEAD_IN = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               st, st_n;
  logic                 start_q, pause_q;
  logic [NUM_LANES-1:0] keys_q;
  logic                 start_rise, pause_rise;
  logic [NUM_LANES-1:0] key_rise;
  logic [ROW_W-1:0]     beat_cnt;
  logic                 last_lead, last_row;
  logic [NUM_LANES-1:0] row0_n, entry;
  logic [SCORE_W-1:0]   score_n;
  logic [7:0]           combo_n, misses_n;
  logic [TRK_W-1:0]     track_n;

  function automatic logic [7:0] sat8_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  // Points per hit: 1 + min(combo/8, 3), taken from the combo before this hit.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s,
                                                   input logic [7:0] c);
    logic [1:0]     bonus;
    logic [SCORE_W:0] sum;
    bonus = (c >= 8'd24) ? 2'd3 : c[4:3];
    sum   = {1'b0, s} + SW1'(bonus) + SW1'(1);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;
  assign key_rise   = keys & ~keys_q;
  assign state      = st;
  assign last_lead  = shift && (beat_cnt == ROW_W'(LEAD_IN - 1));
  assign last_row   = shift && (beat_cnt == ROW_W'(SONG_LEN + TRACK_DEPTH - 1));
  assign entry      = (beat_cnt < ROW_W'(SONG_LEN)) ? rom_data : '0;

  // Hits are judged on the pre-shift hit row; whatever survives is missed on a tick.
  always_comb begin
    row0_n   = track[NUM_LANES-1:0];
    score_n  = score;
    combo_n  = combo;
    misses_n = misses;
    track_n  = track;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (key_rise[i]) begin
        if (row0_n[i]) begin
          row0_n[i] = 1'b0;
          score_n   = score_add(score_n, combo_n);
          combo_n   = sat8_inc(combo_n);
        end else begin
          combo_n  = '0;
          misses_n = sat8_inc(misses_n);
        end
      end
    end
    if (shift) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (row0_n[i]) begin
          combo_n  = '0;
          misses_n = sat8_inc(misses_n);
        end
      end
      track_n = {entry, track[TRK_W-1:NUM_LANES]};
    end else begin
      track_n = {track[TRK_W-1:NUM_LANES], row0_n};
    end
  end

  always_comb begin
    st_n = st;
    if (start_rise) begin
      st_n = S_LEAD_IN;
    end else begin
      case (st)
        S_LEAD_IN: if (last_lead) st_n = S_PLAY;
        S_PLAY: begin
          if (pause_rise)    st_n = S_PAUSE;
          else if (last_row) st_n = S_DONE;
        end
        S_PAUSE:   if (pause_rise) st_n = S_PLAY;
        default:   st_n = st;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st          <= S_IDLE;
      track       <= '0;
      rom_addr    <= '0;
      score       <= '0;
      combo       <= '0;
      misses      <= '0;
      beat_cnt    <= '0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      keys_q      <= '0;
      timer_start <= 1'b0;
      timer_stop  <= 1'b1;
      song_done   <= 1'b0;
    end else begin
      start_q     <= start_btn;
      pause_q     <= pause_btn;
      keys_q      <= keys;
      st          <= st_n;
      timer_start <= (st_n == S_LEAD_IN) || (st_n == S_PLAY);
      timer_stop  <= !((st_n == S_LEAD_IN) || (st_n == S_PLAY));
      song_done   <= (st_n == S_DONE);
      if (start_rise) begin
        track    <= '0;
        rom_addr <= '0;
        score    <= '0;
        combo    <= '0;
        misses   <= '0;
        beat_cnt <= '0;
      end else begin
        case (st)
          S_LEAD_IN: if (shift) beat_cnt <= last_lead ? '0 : beat_cnt + ROW_W'(1);
          S_PLAY: begin
            if (!pause_rise) begin
              track  <= track_n;
              score  <= score_n;
              combo  <= combo_n;
              misses <= misses_n;
              if (shift) begin
                beat_cnt <= beat_cnt + ROW_W'(1);
                // rom_addr parks on the last row once the whole song has been fetched
                if (rom_addr != ADDR_W'(SONG_LEN - 1)) rom_addr <= rom_addr + ADDR_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed vector table, hand-written corner sequences,
// and randomized play checked every cycle against an array-based game model.
module tb_song_sequencer;

  localparam int NL = 3, TD = 8, SL = 64, AW = 6, LI = 4, SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              Reset, start_btn, pause_btn, shift;
  logic [NL-1:0]     keys, rom_data;
  logic [AW-1:0]     rom_addr;
  logic              timer_start, timer_stop, song_done;
  logic [NL*TD-1:0]  track;
  logic [SW-1:0]     score;
  logic [7:0]        combo, misses;
  logic [2:0]        state;

  logic [NL-1:0] rom_mem [SL];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  song_sequencer dut (
    .Clk(clk), .Reset(Reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .shift(shift), .keys(keys), .rom_addr(rom_addr), .rom_data(rom_data),
    .timer_start(timer_start), .timer_stop(timer_stop), .track(track),
    .score(score), .combo(combo), .misses(misses), .state(state),
    .song_done(song_done)
  );

  int errors = 0;
  int checks = 0;

  // Game model: state number, tick counters, and the track as an array of rows.
  int m_state, m_lead, m_play, m_score, m_combo, m_misses;
  int m_track [TD];
  bit m_ps, m_pp;
  int m_pk;

  function automatic void model_clear_song();
    m_lead = 0; m_play = 0; m_score = 0; m_combo = 0; m_misses = 0;
    for (int r = 0; r < TD; r++) m_track[r] = 0;
  endfunction

  function automatic void model_reset();
    m_state = 0;
    model_clear_song();
    m_ps = 0; m_pp = 0; m_pk = 0;
  endfunction

  function automatic void model_step();
    bit sr, pr;
    int kr, n, pts;
    if (Reset) begin
      model_reset();
      return;
    end
    sr = start_btn & ~m_ps;
    pr = pause_btn & ~m_pp;
    kr = int'(keys) & ~m_pk & 7;
    m_ps = start_btn; m_pp = pause_btn; m_pk = int'(keys);
    if (sr) begin
      m_state = 1;
      model_clear_song();
      return;
    end
    case (m_state)
      1: if (shift) begin
        m_lead++;
        if (m_lead == LI) begin m_state = 2; m_lead = 0; end
      end
      2: if (pr) m_state = 3;
      else begin
        for (int i = 0; i < NL; i++) begin
          if (kr[i]) begin
            if (m_track[0][i]) begin
              m_track[0][i] = 1'b0;
              pts = 1 + ((m_combo / 8 > 3) ? 3 : m_combo / 8);
              m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
              m_combo = (m_combo < 255) ? m_combo + 1 : 255;
            end else begin
              m_combo = 0;
              m_misses = (m_misses < 255) ? m_misses + 1 : 255;
            end
          end
        end
        if (shift) begin
          n = $countones(m_track[0]);
          if (n > 0) begin
            m_combo = 0;
            m_misses = (m_misses + n > 255) ? 255 : m_misses + n;
          end
          for (int r = 0; r < TD - 1; r++) m_track[r] = m_track[r+1];
          m_track[TD-1] = (m_play < SL) ? int'(rom_mem[m_play]) : 0;
          m_play++;
          if (m_play == SL + TD) m_state = 4;
        end
      end
      3: if (pr) m_state = 2;
      default: ;
    endcase
  endfunction

  function automatic logic [NL*TD-1:0] model_track();
    logic [NL*TD-1:0] p;
    int v;
    p = '0;
    for (int r = 0; r < TD; r++) begin
      v = m_track[r];
      p[r*NL +: NL] = v[NL-1:0];
    end
    return p;
  endfunction

  function automatic void check_model();
    int exp_addr;
    bit exp_ts;
    logic [NL*TD-1:0] exp_trk;
    exp_addr = (m_play < SL - 1) ? m_play : SL - 1;
    exp_ts   = (m_state == 1) || (m_state == 2);
    exp_trk  = model_track();
    checks++;
    if (state !== 3'(m_state) || track !== exp_trk || score !== SW'(m_score) ||
        combo !== 8'(m_combo) || misses !== 8'(m_misses) || rom_addr !== AW'(exp_addr) ||
        timer_start !== exp_ts || timer_stop !== !exp_ts || song_done !== (m_state == 4)) begin
      errors++;
      $display("FAIL model @%0t: state %0d want %0d, track %h want %h, score %0d want %0d, combo %0d want %0d, misses %0d want %0d, rom_addr %0d want %0d, timers %b%b want %b%b, done %b want %b",
               $time, state, m_state, track, exp_trk, score, m_score, combo, m_combo,
               misses, m_misses, rom_addr, exp_addr, timer_start, timer_stop, exp_ts, !exp_ts,
               song_done, m_state == 4);
    end
  endfunction

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit       start, pause, tick;
    bit [2:0] k;
    int       reps, st, row0, sc, cb, ms;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit s, bit p, bit t, bit [2:0] k, int reps,
                              int st, int row0, int sc, int cb, int ms);
    vec_t v;
    v.start = s; v.pause = p; v.tick = t; v.k = k; v.reps = reps;
    v.st = st; v.row0 = row0; v.sc = sc; v.cb = cb; v.ms = ms;
    tbl.push_back(v);
  endfunction

  initial begin
    int gap;
    Reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; shift = 1'b0; keys = '0;
    for (int i = 0; i < SL; i++) rom_mem[i] = '0;
    rom_mem[0] = 3'b001; rom_mem[1] = 3'b010; rom_mem[2] = 3'b101; rom_mem[3] = 3'b010;
    model_reset();
    cyc(); cyc();
    chk("reset_state", int'(state), 0);
    chk("reset_timer_stop", int'(timer_stop), 1);
    Reset = 1'b0;
    cyc();

    //  start pause tick keys reps | state row0 score combo misses
    add(1, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 3'b000, 3, 1, 0, 0, 0, 0);
    add(0, 0, 1, 3'b000, 1, 2, 0, 0, 0, 0);
    add(0, 0, 1, 3'b000, 7, 2, 0, 0, 0, 0);
    add(0, 0, 1, 3'b000, 1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 3'b001, 1, 2, 0, 1, 1, 0);
    add(0, 0, 1, 3'b000, 1, 2, 2, 1, 1, 0);
    add(0, 0, 1, 3'b000, 1, 2, 5, 1, 0, 1);
    add(0, 0, 1, 3'b000, 1, 2, 2, 1, 0, 3);
    add(0, 0, 1, 3'b010, 1, 2, 0, 2, 1, 3);
    add(0, 1, 0, 3'b000, 1, 3, 0, 2, 1, 3);
    add(0, 1, 1, 3'b001, 1, 3, 0, 2, 1, 3);
    add(0, 0, 0, 3'b000, 1, 3, 0, 2, 1, 3);
    add(0, 1, 0, 3'b000, 1, 2, 0, 2, 1, 3);
    add(0, 0, 0, 3'b100, 1, 2, 0, 2, 0, 4);
    add(1, 1, 0, 3'b000, 1, 1, 0, 0, 0, 0);

    for (int v = 0; v < tbl.size(); v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        start_btn = tbl[v].start; pause_btn = tbl[v].pause;
        shift = tbl[v].tick; keys = tbl[v].k;
        cyc();
        shift = 1'b0;
        cyc();
      end
      chk($sformatf("vec%0d_state", v), int'(state), tbl[v].st);
      chk($sformatf("vec%0d_row0", v), int'(track[NL-1:0]), tbl[v].row0);
      chk($sformatf("vec%0d_score", v), int'(score), tbl[v].sc);
      chk($sformatf("vec%0d_combo", v), int'(combo), tbl[v].cb);
      chk($sformatf("vec%0d_misses", v), int'(misses), tbl[v].ms);
      chk($sformatf("vec%0d_timer_start", v), int'(timer_start),
          int'(tbl[v].st == 1 || tbl[v].st == 2));
    end

    // Sixteen consecutive hits, then pause freeze, then reset mid-PLAY.
    for (int i = 0; i < SL; i++) rom_mem[i] = (i < 16) ? 3'b001 : 3'b000;
    start_btn = 1'b0; pause_btn = 1'b0; keys = '0;
    cyc();
    start_btn = 1'b1;
    cyc();
    chk("lead_state", int'(state), 1);
    for (int t = 1; t <= LI; t++) begin
      shift = 1'b1; cyc(); shift = 1'b0; cyc();
      chk($sformatf("lead_tick%0d_state", t), int'(state), (t == LI) ? 2 : 1);
      chk($sformatf("lead_tick%0d_rom_addr", t), int'(rom_addr), 0);
      chk($sformatf("lead_tick%0d_timer_start", t), int'(timer_start), 1);
    end
    for (int t = 0; t < TD; t++) begin
      shift = 1'b1; cyc(); shift = 1'b0; cyc();
    end
    chk("first_note_row0", int'(track[NL-1:0]), 1);
    for (int h = 0; h < 16; h++) begin
      keys = 3'b001; cyc();
      keys = 3'b000; cyc();
      shift = 1'b1; cyc(); shift = 1'b0; cyc();
    end
    chk("hits16_score", int'(score), 24);
    chk("hits16_combo", int'(combo), 16);
    chk("hits16_misses", int'(misses), 0);
    pause_btn = 1'b1; cyc();
    for (int t = 0; t < 3; t++) begin
      shift = 1'b1; keys = 3'b111; cyc();
      shift = 1'b0; keys = 3'b000; cyc();
    end
    chk("pause_state", int'(state), 3);
    chk("pause_score", int'(score), 24);
    chk("pause_combo", int'(combo), 16);
    chk("pause_misses", int'(misses), 0);
    chk("pause_track", int'(track), 0);
    chk("pause_rom_addr", int'(rom_addr), 24);
    chk("pause_timer_start", int'(timer_start), 0);
    chk("pause_timer_stop", int'(timer_stop), 1);
    pause_btn = 1'b0; cyc();
    pause_btn = 1'b1; cyc();
    chk("resume_state", int'(state), 2);
    Reset = 1'b1;
    cyc();
    chk("reset1_state", int'(state), 0);
    cyc(); cyc();
    chk("reset_mid_state", int'(state), 0);
    chk("reset_mid_track", int'(track), 0);
    chk("reset_mid_score", int'(score), 0);
    chk("reset_mid_timer_stop", int'(timer_stop), 1);
    chk("reset_mid_timer_start", int'(timer_start), 0);
    Reset = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
    cyc();

    // Randomized play against the model.
    for (int i = 0; i < SL; i++)
      rom_mem[i] = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
    start_btn = 1'b1;
    gap = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 699) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 149) == 0) pause_btn = ~pause_btn;
      Reset = ($urandom_range(0, 2999) == 0);
      if (shift) begin
        shift = 1'b0;
        gap = $urandom_range(0, 2);
      end else if (gap > 0) begin
        gap--;
      end else begin
        shift = 1'b1;
      end
      case ($urandom_range(0, 5))
        0: keys = 3'($urandom_range(0, 7));
        1: keys = 3'(m_track[0]);
        2, 3: keys = 3'b000;
        default: ;
      endcase
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
